// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port: assembles MSB-first bytes
// into words and writes them sequentially from address 0.
module imem_loader #(
   parameter int unsigned tam_entrada = 1024,
   parameter int unsigned tam_salida  = 32
) (
   input  logic                            CLK,
   input  logic                            RST_n,
   input  logic                            start,
   input  logic [$clog2(tam_entrada):0]    load_len,
   input  logic                            abort,
   input  logic                            byte_valid,
   input  logic [7:0]                      byte_data,
   output logic                            byte_ready,
   output logic                            we,
   output logic [$clog2(tam_entrada)-1:0]  waddr,
   output logic [tam_salida-1:0]           wdata,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   localparam int unsigned AW = $clog2(tam_entrada);
   localparam int unsigned NB = tam_salida / 8;
   localparam int unsigned BW = $clog2(NB + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

   state_t        state, state_d;
   logic [AW:0]   len;
   logic [AW:0]   word_cnt;
   logic [BW-1:0] byte_cnt;
   logic          accept;
   logic          start_ok;
   logic          done_d;
   logic          err_d;
   logic          last_byte;
   logic          last_word;

   assign last_byte = (byte_cnt == BW'(NB - 1));
   assign last_word = ((word_cnt + (AW+1)'(1)) == len);

   // State register
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state and state-decoded controls; abort outranks everything else
   always_comb begin
      state_d    = state;
      byte_ready = 1'b0;
      we         = 1'b0;
      busy       = (state != IDLE);
      accept     = 1'b0;
      start_ok   = 1'b0;
      err_d      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (load_len == '0)
                  state_d = FINISH;
               else if (load_len > (AW+1)'(tam_entrada))
                  err_d = 1'b1;
               else begin
                  start_ok = 1'b1;
                  state_d  = COLLECT;
               end
            end
         end
         COLLECT: begin
            byte_ready = 1'b1;
            if (abort)
               state_d = IDLE;
            else if (byte_valid) begin
               accept = 1'b1;
               if (last_byte) state_d = WRITE;
            end
         end
         WRITE: begin
            we = 1'b1;
            if (abort)          state_d = IDLE;
            else if (last_word) state_d = FINISH;
            else                state_d = COLLECT;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d = (state_d == FINISH);
   end

   // Datapath: counters, write address, word shift register, status pulses
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         len      <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         waddr    <= '0;
         wdata    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= done_d;
         err  <= err_d;
         if (start_ok) begin
            len      <= load_len;
            word_cnt <= '0;
            byte_cnt <= '0;
            waddr    <= '0;
         end
         if (accept) begin
            wdata    <= tam_salida'({wdata, byte_data});
            byte_cnt <= byte_cnt + BW'(1);
         end
         if (state == WRITE) begin
            byte_cnt <= '0;
            word_cnt <= word_cnt + (AW+1)'(1);
            if (state_d == COLLECT) waddr <= waddr + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are driven with varied valid patterns
// and the observed write port is compared with the word list each load should produce.
module tb_imem_loader;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WW    = 32;
   localparam int unsigned NB    = WW / 8;
   localparam int unsigned AW    = 10;

   typedef logic [7:0]    byte_q_t[$];
   typedef logic [WW-1:0] word_q_t[$];

   logic          CLK = 1'b0;
   logic          RST_n;
   logic          start;
   logic [AW:0]   load_len;
   logic          abort;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [WW-1:0] wdata;
   logic          busy;
   logic          done;
   logic          err;

   imem_loader #(.tam_entrada(DEPTH), .tam_salida(WW)) dut (
      .CLK(CLK), .RST_n(RST_n), .start(start), .load_len(load_len), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observation of the memory write port and status pulses
   logic [AW-1:0] w_addr_q[$];
   logic [WW-1:0] w_data_q[$];
   int            w_cyc_q[$];
   int            acc_cyc_q[$];
   logic [WW-1:0] mem [DEPTH];
   int done_cnt = 0, err_cnt = 0, done_cyc = 0, rdy_we_viol = 0;

   always @(negedge CLK) begin
      if (RST_n === 1'b1) begin
         if (we) begin
            w_addr_q.push_back(waddr);
            w_data_q.push_back(wdata);
            w_cyc_q.push_back(cyc);
            mem[waddr] = wdata;
            if (byte_ready) rdy_we_viol++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err) err_cnt++;
      end
   end

   task automatic clear_obs();
      w_addr_q.delete();
      w_data_q.delete();
      w_cyc_q.delete();
      acc_cyc_q.delete();
   endtask

   task automatic do_start(input int len, output int st_cyc);
      @(negedge CLK);
      start    = 1'b1;
      load_len = (AW+1)'(len);
      st_cyc   = cyc;
      @(negedge CLK);
      start    = 1'b0;
   endtask

   function automatic byte_q_t to_bytes(input word_q_t w);
      byte_q_t b;
      foreach (w[k])
         for (int j = int'(NB) - 1; j >= 0; j--) b.push_back(w[k][8*j +: 8]);
      return b;
   endfunction

   // mode 0: valid held high, 1: toggles every cycle, 2: random
   task automatic send(input byte_q_t b, input int mode);
      int i = 0;
      int guard = 0;
      bit tog = 1'b1;
      while (i < b.size() && guard < 20 * b.size() + 20) begin
         @(negedge CLK);
         byte_data  = b[i];
         byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = !tog;
         #1;
         if (byte_valid && byte_ready) begin
            acc_cyc_q.push_back(cyc);
            i++;
         end
         guard++;
      end
      @(negedge CLK);
      byte_valid = 1'b0;
      if (i < b.size()) check("send_timeout", 64'(i), 64'(b.size()));
   endtask

   task automatic wait_done(input int d0);
      int guard = 0;
      while (done_cnt == d0 && guard < 64) begin
         @(negedge CLK);
         #1;
         guard++;
      end
      if (done_cnt == d0) check("done_timeout", 64'(done_cnt), 64'(d0 + 1));
   endtask

   // Compare observed writes with the ideal sequential word list
   task automatic verify(input string tag, input int len, input word_q_t words, input int d0);
      int bad = 0;
      int lat = 0;
      int n;
      check({tag, "_nwr"}, 64'(w_addr_q.size()), 64'(len));
      n = (w_addr_q.size() < len) ? w_addr_q.size() : len;
      for (int k = 0; k < n; k++) begin
         if (w_addr_q[k] !== AW'(k) || w_data_q[k] !== words[k]) bad++;
         if (acc_cyc_q.size() > NB * k + NB - 1)
            if (w_cyc_q[k] != acc_cyc_q[NB * k + NB - 1] + 1) lat++;
      end
      check({tag, "_data"}, 64'(bad), 64'(0));
      check({tag, "_we_lat"}, 64'(lat), 64'(0));
      if (w_cyc_q.size() > 0) check({tag, "_done_lat"}, 64'(done_cyc), 64'(w_cyc_q[$] + 1));
      @(negedge CLK);
      #1;
      check({tag, "_busy_after"}, 64'(busy), 64'(0));
      check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(1));
      check({tag, "_waddr_hold"}, 64'(waddr), 64'(len - 1));
   endtask

   task automatic run_load(input string tag, input int mode, input word_q_t words);
      int d0;
      int sc;
      clear_obs();
      d0 = done_cnt;
      do_start(words.size(), sc);
      send(to_bytes(words), mode);
      wait_done(d0);
      if (mode == 0 && w_cyc_q.size() > 1)
         check({tag, "_rate"}, 64'(w_cyc_q[1] - w_cyc_q[0]), 64'(NB + 1));
      verify(tag, words.size(), words, d0);
   endtask

   initial begin
      word_q_t ws;
      word_q_t wfull;
      byte_q_t bs;
      int d0, e0, sc, bad;

      RST_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
      load_len = '0; byte_data = '0;
      #12;
      check("reset_outs", 64'({byte_ready, we, busy, done, err, waddr, wdata}), 64'(0));
      @(negedge CLK);
      RST_n = 1'b1;

      ws = '{32'h0000_0013, 32'hDEAD_BEEF};
      run_load("two_held", 0, ws);
      run_load("two_toggle", 1, ws);

      clear_obs();
      d0 = done_cnt;
      do_start(0, sc);
      wait_done(d0);
      check("len0_done_cyc", 64'(done_cyc), 64'(sc + 1));
      check("len0_nwr", 64'(w_addr_q.size()), 64'(0));

      clear_obs();
      e0 = err_cnt;
      d0 = done_cnt;
      do_start(DEPTH + 1, sc);
      #1;
      check("toolong_busy", 64'(busy), 64'(0));
      repeat (4) @(negedge CLK);
      #1;
      check("toolong_err", 64'(err_cnt - e0), 64'(1));
      check("toolong_nwr", 64'(w_addr_q.size() + done_cnt - d0), 64'(0));

      for (int r = 0; r < 6; r++) begin
         ws.delete();
         for (int k = 0; k < int'($urandom_range(1, 8)); k++) ws.push_back($urandom);
         run_load($sformatf("rand%0d", r), 2, ws);
      end

      wfull.delete();
      for (int k = 0; k < int'(DEPTH); k++) wfull.push_back(WW'(k));
      run_load("full", 0, wfull);
      check("full_last", 64'({w_addr_q[$], w_data_q[$]}), 64'({AW'(DEPTH - 1), 32'h0000_03FF}));
      bad = 0;
      for (int k = 0; k < int'(DEPTH); k++) if (mem[k] !== WW'(k)) bad++;
      check("full_mem", 64'(bad), 64'(0));

      // Abort two bytes into the fourth word of a five-word load
      ws.delete();
      for (int k = 0; k < 5; k++) ws.push_back($urandom);
      bs = to_bytes(ws);
      clear_obs();
      d0 = done_cnt;
      do_start(5, sc);
      send(bs[0:3*NB+1], 0);
      @(negedge CLK);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      repeat (10) @(negedge CLK);
      #1;
      check("abort_nwr", 64'(w_addr_q.size()), 64'(3));
      bad = 0;
      for (int k = 0; k < w_addr_q.size() && k < 3; k++)
         if (w_addr_q[k] !== AW'(k) || w_data_q[k] !== ws[k]) bad++;
      check("abort_data", 64'(bad), 64'(0));
      check("abort_nodone", 64'(done_cnt - d0), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      ws = '{32'(~ws[0])};
      run_load("post_abort", 2, ws);

      // Asynchronous reset in the middle of a word
      ws = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
      clear_obs();
      do_start(3, sc);
      bs = to_bytes(ws);
      send(bs[0:5], 0);
      @(posedge CLK);
      #2;
      RST_n = 1'b0;
      #1;
      check("midreset_outs", 64'({byte_ready, we, busy, done, err, waddr, wdata}), 64'(0));
      @(negedge CLK);
      RST_n = 1'b1;

      // A second start while busy must not restart the load
      ws = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
      clear_obs();
      d0 = done_cnt;
      do_start(2, sc);
      @(negedge CLK);
      start = 1'b1;
      load_len = (AW+1)'(1);
      repeat (2) @(negedge CLK);
      start = 1'b0;
      send(to_bytes(ws), 2);
      wait_done(d0);
      verify("start_busy", 2, ws, d0);

      check("ready_in_write", 64'(rdy_we_viol), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
